// File: rtl/pipe_stage_elastic_if.sv
// pipe_stage_elastic_if: valid/ready/data handshake bundle for one side of a pipeline stage.
//   valid  producer -> consumer  payload valid
//   ready  consumer -> producer  consumer accepts payload this cycle
//   data   producer -> consumer  packed stage payload (DATA_W bits)
interface pipe_stage_elastic_if #(parameter int DATA_W = 256);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready elastic pipeline register with optional skid entry, flush and stall counter.
//   clk        clock, all state updates on rising edge
//   rset       asynchronous active-low reset
//   flush      synchronous kill of all held payload, active-high
//   up         slave side: in_valid / in_ready / in_data
//   dn         master side: out_valid / out_ready / out_data (main register)
//   stall_cnt  saturating count of consecutive cycles the head payload has waited
module pipe_stage_elastic #(
  parameter int DATA_W = 256,
  parameter int SKID   = 1,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rset,
  input  logic                    flush,
  pipe_stage_elastic_if.slave     up,
  pipe_stage_elastic_if.master    dn,
  output logic [CNT_W-1:0]        stall_cnt
);
  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b01;
  localparam logic [1:0] S_FULL  = 2'b11;
  logic              r_main_v;
  logic              r_skid_v;
  logic [DATA_W-1:0] r_main_d;
  logic [DATA_W-1:0] r_skid_d;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        w_state;
  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  assign w_state    = {r_skid_v, r_main_v};
  // With a skid entry, ready depends only on registered state; without it, ready looks through to out_ready.
  assign w_in_ready = rset && ((SKID != 0) ? (w_state != S_FULL) : (w_state == S_EMPTY || dn.ready));
  assign w_in_fire  = up.valid && w_in_ready;
  assign w_out_fire = r_main_v && dn.ready;
  assign up.ready   = w_in_ready;
  assign dn.valid   = r_main_v;
  assign dn.data    = r_main_d;
  assign stall_cnt  = r_cnt;
  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= '0;
      r_skid_d <= '0;
      r_cnt    <= '0;
    end else if (flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= '0;
      r_skid_d <= '0;
      r_cnt    <= '0;
    end else begin
      r_cnt <= (!r_main_v || w_out_fire) ? '0 : ((&r_cnt) ? r_cnt : r_cnt + 1'b1);
      if (w_out_fire) begin
        if (r_skid_v) begin
          // FULL drains the skid entry into main; in_ready is low so nothing new arrives.
          r_main_d <= r_skid_d;
          r_skid_v <= 1'b0;
        end else if (w_in_fire) begin
          r_main_d <= up.data;
        end else begin
          r_main_v <= 1'b0;
        end
      end else if (w_in_fire) begin
        // Only reachable with main occupied when the skid entry exists.
        if (r_main_v && SKID != 0) begin
          r_skid_d <= up.data;
          r_skid_v <= 1'b1;
        end else begin
          r_main_d <= up.data;
          r_main_v <= 1'b1;
        end
      end
    end
  end
  a_state_legal: assert property (@(posedge clk) disable iff (!rset)
    w_state == S_EMPTY || w_state == S_ONE || w_state == S_FULL);
endmodule
